// File: rtl/tilegen_layer_mixer_pkg.sv
// tilegen_layer_mixer_pkg: shared constants, candidate record and reset-default helper for the layer mixer.
// Contents: register addresses (background, solo), transparent-pen constant,
// reset-default priority function, candidate record carried through the compare tree.
package tilegen_mixer_pkg;

    localparam logic [3:0] ADDR_BG         = 4'hF;
    localparam logic [3:0] ADDR_SOLO       = 4'hE;
    localparam logic [3:0] ID_BG           = 4'hF;
    // All-ones pen is transparent; sliced down to the configured pen width.
    localparam logic [7:0] PEN_TRANSPARENT = 8'hFF;

    // Fields are sized for the widest legal configuration and zero-extended.
    typedef struct packed {
        logic       valid;
        logic [7:0] pri;
        logic [7:0] cl;
        logic [7:0] dt;
        logic [3:0] id;
    } cand_t;

    function automatic logic [7:0] default_pri(input int unsigned idx);
        return 8'(idx);
    endfunction

endpackage

// File: rtl/tilegen_layer_mixer_if.sv
// tilegen_layer_mixer_if: pixel, CPU register and output bundle of the layer mixer.
// master: pixel/CPU driver (drives PIXEL_EN..nWE, receives CLO..VALID).
// slave : the mixer (receives PIXEL_EN..nWE, drives CLO..VALID).
interface tilegen_layer_mixer_if #(
    parameter int LAYER_COUNT = 4,
    parameter int PR_WIDTH    = 3,
    parameter int CL_WIDTH    = 8,
    parameter int DT_WIDTH    = 3
);
    logic                            PIXEL_EN;
    logic                            nBLANK;
    logic                            nVSYNC;
    logic [LAYER_COUNT*CL_WIDTH-1:0] LAYER_CL;
    logic [LAYER_COUNT*DT_WIDTH-1:0] LAYER_DT;
    logic [3:0]                      CA;
    logic [7:0]                      CD;
    logic                            nCS;
    logic                            nWE;
    logic [CL_WIDTH-1:0]             CLO;
    logic [DT_WIDTH-1:0]             DTO;
    logic [PR_WIDTH-1:0]             PRO;
    logic [3:0]                      LAYER_ID;
    logic                            VALID;

    modport master (
        output PIXEL_EN, nBLANK, nVSYNC, LAYER_CL, LAYER_DT, CA, CD, nCS, nWE,
        input  CLO, DTO, PRO, LAYER_ID, VALID
    );
    modport slave (
        input  PIXEL_EN, nBLANK, nVSYNC, LAYER_CL, LAYER_DT, CA, CD, nCS, nWE,
        output CLO, DTO, PRO, LAYER_ID, VALID
    );
endinterface

// File: rtl/tilegen_layer_mixer_cmp.sv
// tilegen_mixer_cmp: registered two-input priority compare node with pixel-strobe hold.
// Ports: clk, rst_n (async active-low), i_en (pixel strobe), i_a (lower-index side),
// i_b (higher-index side), o_y (registered winner).
module tilegen_mixer_cmp
    import tilegen_mixer_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_en,
    input  cand_t i_a,
    input  cand_t i_b,
    output cand_t o_y
);
    cand_t r_y;
    logic  w_pick_b;

    // b must be strictly higher to win, so ties go to the lower-index side a.
    assign w_pick_b = i_b.valid && (!i_a.valid || i_b.pri > i_a.pri);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_y <= '0;
        else if (i_en)
            r_y <= w_pick_b ? i_b : i_a;
    end

    assign o_y = r_y;
endmodule

// File: rtl/tilegen_layer_mixer.sv
// tilegen_layer_mixer: N-layer tile priority compositor with frame-synchronised CPU registers.
// Ports: CLK_6M clock, rst_n async active-low reset, bus (tilegen_layer_mixer_if.slave):
// pixel inputs PIXEL_EN/nBLANK/LAYER_CL/LAYER_DT, CPU port CA/CD/nCS/nWE, frame sync nVSYNC,
// outputs CLO/DTO/PRO/LAYER_ID/VALID after clog2(LAYER_COUNT)+2 pixel strobes.
// Optional feature macro: TILEGEN_MIXER_SOLO_EN adds the solo register at CA=4'hE.
module tilegen_layer_mixer
    import tilegen_mixer_pkg::*;
#(
    parameter int                     LAYER_COUNT        = 4,
    parameter int                     PR_WIDTH           = 3,
    parameter int                     CL_WIDTH           = 8,
    parameter int                     DT_WIDTH           = 3,
    parameter logic [LAYER_COUNT-1:0] LAYER_DISABLE_MASK = '0
)(
    input logic                   CLK_6M,
    input logic                   rst_n,
    tilegen_layer_mixer_if.slave  bus
);
    localparam int D = $clog2(LAYER_COUNT);
    localparam int P = 1 << D;

    logic                   r_vs;
    logic                   w_wr;
    logic                   w_commit;
    logic [PR_WIDTH-1:0]    r_stg_pri [LAYER_COUNT];
    logic [PR_WIDTH-1:0]    r_act_pri [LAYER_COUNT];
    logic [LAYER_COUNT-1:0] r_stg_dis;
    logic [LAYER_COUNT-1:0] r_act_dis;
    logic [CL_WIDTH-1:0]    r_stg_bg;
    logic [CL_WIDTH-1:0]    r_act_bg;
    logic [LAYER_COUNT-1:0] w_solo_ok;
`ifdef TILEGEN_MIXER_SOLO_EN
    logic                   r_stg_solo_en;
    logic                   r_act_solo_en;
    logic [3:0]             r_stg_solo_id;
    logic [3:0]             r_act_solo_id;
`endif

    assign w_wr     = !bus.nCS && !bus.nWE;
    // Falling nVSYNC: previous sample high, current sample low.
    assign w_commit = r_vs && !bus.nVSYNC;

    // Active copies take the pre-write staging values because both update with <= in one edge.
    always_ff @(posedge CLK_6M or negedge rst_n) begin
        if (!rst_n) begin
            r_vs <= 1'b0;
            for (int i = 0; i < LAYER_COUNT; i++) begin
                r_stg_pri[i] <= PR_WIDTH'(default_pri(i));
                r_act_pri[i] <= PR_WIDTH'(default_pri(i));
            end
            r_stg_dis <= '0;
            r_act_dis <= '0;
            r_stg_bg  <= '0;
            r_act_bg  <= '0;
`ifdef TILEGEN_MIXER_SOLO_EN
            r_stg_solo_en <= 1'b0;
            r_act_solo_en <= 1'b0;
            r_stg_solo_id <= '0;
            r_act_solo_id <= '0;
`endif
        end else begin
            r_vs <= bus.nVSYNC;
            for (int i = 0; i < LAYER_COUNT; i++) begin
                if (w_wr && bus.CA == 4'(i)) begin
                    r_stg_pri[i] <= bus.CD[PR_WIDTH-1:0];
                    r_stg_dis[i] <= bus.CD[7];
                end
            end
            if (w_wr && bus.CA == ADDR_BG)
                r_stg_bg <= bus.CD[CL_WIDTH-1:0];
`ifdef TILEGEN_MIXER_SOLO_EN
            if (w_wr && bus.CA == ADDR_SOLO) begin
                r_stg_solo_en <= bus.CD[7];
                r_stg_solo_id <= bus.CD[3:0];
            end
`endif
            if (w_commit) begin
                r_act_pri <= r_stg_pri;
                r_act_dis <= r_stg_dis;
                r_act_bg  <= r_stg_bg;
`ifdef TILEGEN_MIXER_SOLO_EN
                r_act_solo_en <= r_stg_solo_en;
                r_act_solo_id <= r_stg_solo_id;
`endif
            end
        end
    end

    // Solo index beyond the layer count matches no layer, leaving background only.
    for (genvar i = 0; i < LAYER_COUNT; i++) begin : g_solo
`ifdef TILEGEN_MIXER_SOLO_EN
        assign w_solo_ok[i] = !r_act_solo_en || r_act_solo_id == 4'(i);
`else
        assign w_solo_ok[i] = 1'b1;
`endif
    end

    cand_t w_cand [P];
    cand_t r_leaf [P];
    cand_t w_node [P-1];
    logic [D:0] r_bl;

    // Leaves past LAYER_COUNT pad the tree to a power of two and never win.
    for (genvar i = 0; i < P; i++) begin : g_leaf
        if (i < LAYER_COUNT) begin : g_real
            logic [DT_WIDTH-1:0] w_dt;
            assign w_dt      = bus.LAYER_DT[i*DT_WIDTH +: DT_WIDTH];
            assign w_cand[i] = '{
                valid: w_dt != PEN_TRANSPARENT[DT_WIDTH-1:0] && !r_act_dis[i]
                       && !LAYER_DISABLE_MASK[i] && w_solo_ok[i],
                pri:   8'(r_act_pri[i]),
                cl:    8'(bus.LAYER_CL[i*CL_WIDTH +: CL_WIDTH]),
                dt:    8'(w_dt),
                id:    4'(i)
            };
        end else begin : g_pad
            assign w_cand[i] = '0;
        end
    end

    always_ff @(posedge CLK_6M or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P; i++)
                r_leaf[i] <= '0;
            r_bl <= '0;
        end else if (bus.PIXEL_EN) begin
            r_leaf <= w_cand;
            r_bl   <= {r_bl[D-1:0], bus.nBLANK};
        end
    end

    // Heap-ordered tree: node j has children 2j+1 (lower layers) and 2j+2; leaves sit at P-1..2P-2.
    for (genvar j = 0; j < P - 1; j++) begin : g_node
        cand_t w_a;
        cand_t w_b;
        if (2*j + 1 >= P - 1) begin : g_lf
            assign w_a = r_leaf[2*j + 1 - (P - 1)];
            assign w_b = r_leaf[2*j + 2 - (P - 1)];
        end else begin : g_in
            assign w_a = w_node[2*j + 1];
            assign w_b = w_node[2*j + 2];
        end
        tilegen_mixer_cmp u_cmp (
            .clk   (CLK_6M),
            .rst_n (rst_n),
            .i_en  (bus.PIXEL_EN),
            .i_a   (w_a),
            .i_b   (w_b),
            .o_y   (w_node[j])
        );
    end

    cand_t               w_root;
    logic                w_show;
    logic [CL_WIDTH-1:0] r_clo;
    logic [DT_WIDTH-1:0] r_dto;
    logic [PR_WIDTH-1:0] r_pro;
    logic [3:0]          r_id;
    logic                r_valid;
    logic                w_unused;

    assign w_root = w_node[0];
    assign w_show = w_root.valid && r_bl[D];

    always_ff @(posedge CLK_6M or negedge rst_n) begin
        if (!rst_n) begin
            r_clo   <= '0;
            r_dto   <= '1;
            r_pro   <= '0;
            r_id    <= ID_BG;
            r_valid <= 1'b0;
        end else if (bus.PIXEL_EN) begin
            r_clo   <= w_show ? w_root.cl[CL_WIDTH-1:0] : r_act_bg;
            r_dto   <= w_show ? w_root.dt[DT_WIDTH-1:0] : '1;
            r_pro   <= w_show ? w_root.pri[PR_WIDTH-1:0] : '0;
            r_id    <= w_show ? w_root.id : ID_BG;
            r_valid <= r_bl[D];
        end
    end

    assign bus.CLO      = r_clo;
    assign bus.DTO      = r_dto;
    assign bus.PRO      = r_pro;
    assign bus.LAYER_ID = r_id;
    assign bus.VALID    = r_valid;

    assign w_unused = ^{bus.CD, w_root};
endmodule

// File: tb/tb_tilegen_layer_mixer.sv
// tb_tilegen_layer_mixer: scoreboard bench for tilegen_layer_mixer (4 layers, default widths).
module tb_tilegen_layer_mixer;
    localparam int L = 4;
    localparam logic [18:0] RST_OUT = {8'h00, 3'h7, 3'h0, 4'hF, 1'b0};
    localparam logic [31:0] CLS     = 32'h33_22_11_10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tilegen_layer_mixer_if #(.LAYER_COUNT(4), .PR_WIDTH(3), .CL_WIDTH(8), .DT_WIDTH(3)) bus ();

    tilegen_layer_mixer #(
        .LAYER_COUNT(4), .PR_WIDTH(3), .CL_WIDTH(8), .DT_WIDTH(3), .LAYER_DISABLE_MASK(4'b0000)
    ) dut (
        .CLK_6M (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic       show;
        logic [7:0] cl;
        logic [2:0] dt;
        logic [2:0] pri;
        logic [3:0] id;
        logic       bl;
    } exp_t;

    exp_t        q[$];
    logic [18:0] last_exp;
    int          n_vec = 0;
    int          n_err = 0;
    int          m_spri[4], m_apri[4];
    bit          m_sdis[4], m_adis[4];
    logic [7:0]  m_sbg, m_abg;
    bit          m_ssolo_en, m_asolo_en;
    logic [3:0]  m_ssolo_id, m_asolo_id;

    function automatic logic [11:0] pens(input int p0, input int p1, input int p2, input int p3);
        return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    function automatic logic [18:0] out_of(input exp_t e);
        return {e.show ? e.cl : m_abg, e.show ? e.dt : 3'h7, e.show ? e.pri : 3'h0,
                e.show ? e.id : 4'hF, e.bl};
    endfunction

    task automatic model_reset();
        exp_t z;
        for (int i = 0; i < 4; i++) begin
            m_spri[i] = i; m_apri[i] = i; m_sdis[i] = 0; m_adis[i] = 0;
        end
        m_sbg = 0; m_abg = 0;
        m_ssolo_en = 0; m_asolo_en = 0; m_ssolo_id = 0; m_asolo_id = 0;
        q.delete();
        z = '{show: 1'b0, cl: 8'h00, dt: 3'h7, pri: 3'h0, id: 4'hF, bl: 1'b0};
        for (int i = 0; i < L - 1; i++) q.push_back(z);
    endtask

    task automatic stage_write(input logic [3:0] ca, input logic [7:0] cd);
        if (ca < 4) begin
            m_spri[ca] = int'(cd[2:0]);
            m_sdis[ca] = cd[7];
        end else if (ca == 4'hF) begin
            m_sbg = cd;
        end
`ifdef TILEGEN_MIXER_SOLO_EN
        else if (ca == 4'hE) begin
            m_ssolo_en = cd[7];
            m_ssolo_id = cd[3:0];
        end
`endif
    endtask

    task automatic wr(input logic [3:0] ca, input logic [7:0] cd);
        @(negedge clk);
        bus.CA = ca; bus.CD = cd; bus.nCS = 1'b0; bus.nWE = 1'b0;
        @(posedge clk);
        stage_write(ca, cd);
        #1 bus.nCS = 1'b1; bus.nWE = 1'b1;
    endtask

    task automatic commit(input bit with_wr, input logic [3:0] ca, input logic [7:0] cd);
        @(negedge clk);
        bus.nVSYNC = 1'b0;
        if (with_wr) begin
            bus.CA = ca; bus.CD = cd; bus.nCS = 1'b0; bus.nWE = 1'b0;
        end
        @(posedge clk);
        m_apri = m_spri; m_adis = m_sdis; m_abg = m_sbg;
        m_asolo_en = m_ssolo_en; m_asolo_id = m_ssolo_id;
        if (with_wr) stage_write(ca, cd);
        #1 bus.nCS = 1'b1; bus.nWE = 1'b1;
        @(negedge clk);
        bus.nVSYNC = 1'b1;
    endtask

    task automatic strobe(input string tag, input logic [31:0] cl, input logic [11:0] dt, input logic bl);
        exp_t        e;
        int          best;
        logic [18:0] got;
        @(negedge clk);
        bus.LAYER_CL = cl; bus.LAYER_DT = dt; bus.nBLANK = bl; bus.PIXEL_EN = 1'b1;
        best = -1;
        for (int i = 0; i < 4; i++) begin
            if (dt[i*3 +: 3] != 3'h7 && !m_adis[i] && (!m_asolo_en || m_asolo_id == 4'(i))
                && (best < 0 || m_apri[i] > m_apri[best]))
                best = i;
        end
        e.show = bl && best >= 0;
        e.cl   = best >= 0 ? cl[best*8 +: 8] : 8'h00;
        e.dt   = best >= 0 ? dt[best*3 +: 3] : 3'h7;
        e.pri  = best >= 0 ? 3'(m_apri[best]) : 3'h0;
        e.id   = best >= 0 ? 4'(best) : 4'hF;
        e.bl   = bl;
        q.push_back(e);
        @(posedge clk);
        #1 bus.PIXEL_EN = 1'b0;
        e = q.pop_front();
        last_exp = out_of(e);
        got = {bus.CLO, bus.DTO, bus.PRO, bus.LAYER_ID, bus.VALID};
        n_vec++;
        if (got !== last_exp) begin
            n_err++;
            $display("FAIL %s: {CLO,DTO,PRO,ID,VALID} got %h want %h", tag, got, last_exp);
        end
    endtask

    task automatic test_reset();
        logic [18:0] got;
        repeat (3) @(negedge clk);
        got = {bus.CLO, bus.DTO, bus.PRO, bus.LAYER_ID, bus.VALID};
        n_vec++;
        if (got !== RST_OUT) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want %h", got, RST_OUT);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_default_priority();
        logic [18:0] got;
        repeat (4) strobe("default_pri", CLS, pens(2, 7, 7, 5), 1'b1);
        got = {bus.CLO, bus.DTO, bus.PRO, bus.LAYER_ID, bus.VALID};
        n_vec++;
        if (got !== {8'h33, 3'd5, 3'd3, 4'd3, 1'b1}) begin
            n_err++;
            $display("FAIL default_layer3: got %h want %h", got, {8'h33, 3'd5, 3'd3, 4'd3, 1'b1});
        end
    endtask

    task automatic test_staged_commit();
        logic [18:0] got;
        wr(4'h0, 8'h07);
        repeat (4) strobe("staged_hold", CLS, pens(2, 7, 7, 5), 1'b1);
        commit(0, 4'h0, 8'h00);
        repeat (4) strobe("after_commit", CLS, pens(2, 7, 7, 5), 1'b1);
        got = {bus.CLO, bus.DTO, bus.PRO, bus.LAYER_ID, bus.VALID};
        n_vec++;
        if (got !== {8'h10, 3'd2, 3'd7, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL commit_layer0: got %h want %h", got, {8'h10, 3'd2, 3'd7, 4'd0, 1'b1});
        end
    endtask

    task automatic test_tie();
        wr(4'h3, 8'h07);
        commit(0, 4'h0, 8'h00);
        repeat (4) strobe("tie_low_index", CLS, pens(2, 7, 7, 5), 1'b1);
        wr(4'h0, 8'h87);
        commit(0, 4'h0, 8'h00);
        repeat (4) strobe("soft_disable", CLS, pens(2, 7, 7, 5), 1'b1);
    endtask

    task automatic test_commit_race();
        commit(1, 4'h1, 8'h06);
        repeat (4) strobe("race_old_value", CLS, pens(7, 3, 7, 7), 1'b1);
        commit(0, 4'h0, 8'h00);
        repeat (4) strobe("race_next_commit", CLS, pens(7, 3, 7, 7), 1'b1);
    endtask

    task automatic test_background();
        wr(4'hF, 8'hA5);
        commit(0, 4'h0, 8'h00);
        repeat (4) strobe("bg_transparent", CLS, pens(7, 7, 7, 7), 1'b1);
        repeat (4) strobe("bg_blank", CLS, pens(1, 2, 3, 4), 1'b0);
    endtask

    task automatic test_freeze();
        logic [18:0] got;
        for (int k = 0; k < 3; k++)
            strobe("pre_freeze", CLS + 32'(k * 32'h01010101), pens(k, k + 1, 7, k), 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.LAYER_DT = 12'($urandom);
            bus.nBLANK = 1'($urandom);
            got = {bus.CLO, bus.DTO, bus.PRO, bus.LAYER_ID, bus.VALID};
            n_vec++;
            if (got !== last_exp) begin
                n_err++;
                $display("FAIL freeze_hold cycle %0d: got %h want %h", c, got, last_exp);
            end
        end
        for (int k = 3; k < 9; k++)
            strobe("post_freeze", CLS + 32'(k * 32'h01010101), pens(k % 7, 7, k % 5, 7), 1'b1);
    endtask

    task automatic test_random();
        logic [11:0] dt;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++)
                wr(4'(i), {1'($urandom_range(0, 3) == 0), 4'h0, 3'($urandom)});
            commit(0, 4'h0, 8'h00);
            for (int k = 0; k < 12; k++) begin
                for (int i = 0; i < 4; i++)
                    dt[i*3 +: 3] = $urandom_range(0, 3) == 0 ? 3'h7 : 3'($urandom_range(0, 6));
                if ($urandom_range(0, 3) == 0) @(negedge clk);
                strobe("random", $urandom, dt, 1'($urandom_range(0, 7) != 0));
            end
        end
    endtask

`ifdef TILEGEN_MIXER_SOLO_EN
    task automatic test_solo();
        wr(4'hE, 8'h81);
        commit(0, 4'h0, 8'h00);
        repeat (4) strobe("solo_layer1", CLS, pens(2, 3, 4, 5), 1'b1);
        wr(4'hE, 8'h89);
        commit(0, 4'h0, 8'h00);
        repeat (4) strobe("solo_out_of_range", CLS, pens(2, 3, 4, 5), 1'b1);
        wr(4'hE, 8'h00);
        commit(0, 4'h0, 8'h00);
        repeat (4) strobe("solo_off", CLS, pens(2, 3, 4, 5), 1'b1);
    endtask
`endif

    task automatic test_async_reset();
        logic [18:0] got;
        wr(4'hF, 8'h5A);
        commit(0, 4'h0, 8'h00);
        repeat (4) strobe("pre_reset", CLS, pens(1, 7, 7, 7), 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 got = {bus.CLO, bus.DTO, bus.PRO, bus.LAYER_ID, bus.VALID};
        n_vec++;
        if (got !== RST_OUT) begin
            n_err++;
            $display("FAIL async_reset: got %h want %h", got, RST_OUT);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) strobe("post_reset", CLS, pens(2, 7, 7, 5), 1'b1);
        repeat (4) strobe("post_reset_blank", CLS, pens(7, 7, 7, 7), 1'b1);
    endtask

    initial begin
        bus.PIXEL_EN = 1'b0; bus.nBLANK = 1'b1; bus.nVSYNC = 1'b1;
        bus.LAYER_CL = '0; bus.LAYER_DT = '1;
        bus.CA = '0; bus.CD = '0; bus.nCS = 1'b1; bus.nWE = 1'b1;
        test_reset();
        test_default_priority();
        test_staged_commit();
        test_tie();
        test_commit_race();
        test_background();
        test_freeze();
        test_random();
`ifdef TILEGEN_MIXER_SOLO_EN
        test_solo();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tilegen_layer_mixer.md
# tilegen_layer_mixer

Parametrised N-layer tile priority compositor for the tile generation subsystem. It replaces the fixed two-deep chain of per-chip priority/colour/dot pass-through with a single pipelined block. The block accepts LAYER_COUNT decoded tile pixels, applies CPU-programmed, frame-synchronised priorities, enables and background colour, and emits one winning colour/dot/priority per pixel toward the tile palette PROM lookup. It sits between the per-layer tile data shifters and the palette address bus.

## Interface
Parameters:
- LAYER_COUNT, 4, number of input layers (2..14)
- PR_WIDTH, 3, priority width
- CL_WIDTH, 8, colour (palette bank) width
- DT_WIDTH, 3, dot/pen width; all-ones pen = transparent
- LAYER_DISABLE_MASK, 0, LAYER_COUNT-bit hard disable; set bits never win

Ports:
- CLK_6M  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- PIXEL_EN  in  1  one-cycle pixel strobe; pipeline advances only when high
- nBLANK  in  1  low = outside active display, sampled with pixel data
- nVSYNC  in  1  frame sync; falling edge commits staged registers
- LAYER_CL  in  LAYER_COUNT*CL_WIDTH  per-layer colour, layer i at [i*CL_WIDTH +: CL_WIDTH]
- LAYER_DT  in  LAYER_COUNT*DT_WIDTH  per-layer pen, same packing
- CA  in  4  register address
- CD  in  8  register write data
- nCS  in  1  register select, active-low
- nWE  in  1  write strobe, active-low
- CLO  out  CL_WIDTH  winning colour
- DTO  out  DT_WIDTH  winning pen
- PRO  out  PR_WIDTH  winning priority
- LAYER_ID  out  4  winning layer index; 4'hF = background
- VALID  out  1  delayed nBLANK

## Operation
- Register write: CLK_6M rising with nCS=0 and nWE=0 writes CD into the staging register at CA. Writes are accepted regardless of PIXEL_EN.
- Register map: CA=i (i<LAYER_COUNT) is layer i. CD[PR_WIDTH-1:0] is the priority. CD[7] is the soft disable. CA=4'hF is the background colour, CD[CL_WIDTH-1:0]. All other addresses are ignored.
- Commit: a falling edge of nVSYNC, detected synchronously as registered-high then sampled-low, copies all staging registers into the active registers in that cycle. On a write and a commit in the same cycle, the active registers take the pre-write staging value, and the write takes effect at the next commit.
- Candidate rule: layer i is a candidate when LAYER_DT[i] != all-ones, active disable=0, and LAYER_DISABLE_MASK[i]=0.
- Winner: the candidate with the highest active priority. On equal priority, the lower layer index wins.
- No candidate, or sampled nBLANK=0: CLO=background colour, DTO=all-ones, PRO=0, LAYER_ID=4'hF.
- Non-power-of-two LAYER_COUNT: the comparison tree is padded with permanently non-candidate leaves.

## Timing
- Latency is L = clog2(LAYER_COUNT)+2 PIXEL_EN strobes. That is one input-register stage, clog2 compare stages, and one output/background-substitute stage. With the default of 4 layers, L=4.
- While PIXEL_EN=0, all pipeline stages and outputs hold their values.
- nBLANK travels down the pipeline with its pixel, and VALID equals it at the output.
- Active registers feed stage 1, so a commit affects pixels sampled at the next PIXEL_EN onward.
- Reset behaviour:
  - Staging and active registers return to: priority of layer i = i, soft disables clear, background = 0, solo off.
  - All pipeline stages clear to non-candidate with blank.
  - Outputs: CLO=0, DTO=all-ones, PRO=0, LAYER_ID=4'hF, VALID=0.
- Reset asserted mid-frame clears state immediately. No commit occurs until a new nVSYNC falling edge is seen after reset release.

## Configuration
- TILEGEN_MIXER_SOLO_EN defined: CA=4'hE becomes the solo register. CD[7] enables solo and CD[3:0] selects the layer. While active solo is enabled, only that layer may be a candidate. An index ≥ LAYER_COUNT yields background only. The register is staged and committed like the others.
- Not defined: writes to CA=4'hE are ignored, and no solo logic exists.

## Structure
- Package tilegen_mixer_pkg holds:
  - register address constants (background, solo)
  - the transparent-pen constant
  - reset-default priority function
  - the candidate record typedef: valid, priority, colour, pen, layer index
- Sub-module tilegen_mixer_cmp is a registered two-input compare node with a PIXEL_EN hold and the tie rule. It is instantiated in a generate-built tree.

## Test plan
- After reset, staged priorities are default: layer0 pen 2 colour 0x10, layer3 pen 5 colour 0x33, all others pen 7. After 4 strobes: CLO=0x33, DTO=5, PRO=3, LAYER_ID=3.
- Write CA=0 CD=0x07 mid-frame: output unchanged until nVSYNC falls. From the first pixel after the edge: LAYER_ID=0, PRO=7.
- Write CA=3 CD=0x07 while layer0 also has priority 7: layer0 wins the tie. Then write CA=0 CD=0x87 and commit: layer3 wins.
- Write background 0xA5, commit, all pens 7: CLO=0xA5, DTO=7, LAYER_ID=F. With nBLANK=0 and opaque pens, the same output appears and VALID=0.
- Hold PIXEL_EN low 10 cycles mid-stream: outputs frozen. The pixel sequence resumes intact and each pixel still arrives after exactly 4 strobes.
- With TILEGEN_MIXER_SOLO_EN, write CA=E CD=0x81 and commit: only layer1 is shown. Assert rst_n low mid-line: outputs go immediately to their reset values.
